// File: rtl/tow_pkg.sv
// Shared types and constants for the tug-of-war round/score controller.
package tow_pkg;

  typedef enum logic [1:0] {
    PLAY     = 2'd0,
    POINT    = 2'd1,
    RECENTER = 2'd2,
    OVER     = 2'd3
  } tow_state_t;

  localparam int              LFSR_W    = 10;
  localparam logic [LFSR_W-1:0] LFSR_SEED = 10'h001;

endpackage : tow_pkg

// File: rtl/key_pulse.sv
// Raw key conditioning: two-flop synchroniser followed by a registered rising-edge detect.
// A held key produces a single one-cycle pulse, three clock edges after it is first sampled high.
module key_pulse (
  input  logic clk,
  input  logic reset,
  input  logic raw,
  output logic pulse
);

  logic sync_q1;
  logic sync_q2;
  logic prev_q;

  // NOTE: non-blocking assignments make each stage take the previous stage's old value,
  // which is what turns these three statements into a shift chain rather than a wire.
  always_ff @(posedge clk) begin
    if (reset) begin
      sync_q1 <= 1'b0;
      sync_q2 <= 1'b0;
      prev_q  <= 1'b0;
      pulse   <= 1'b0;
    end else begin
      sync_q1 <= raw;
      sync_q2 <= sync_q1;
      prev_q  <= sync_q2;
      pulse   <= sync_q2 & ~prev_q;
    end
  end

endmodule : key_pulse

// File: rtl/tug_of_war_ctrl.sv
// Round/score controller for the tug-of-war light chain.
// Define CPU_PLAYER_EN to replace the right key with an LFSR-driven CPU player.
module tug_of_war_ctrl
  import tow_pkg::*;
#(
  parameter int SCORE_MAX   = 7,
  parameter int SW          = 3,
  parameter int HOLD_CYCLES = 4,
  parameter int CPU_THRESH  = 200
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          key_l,
  input  logic          key_r,
  input  logic          edge_l_on,
  input  logic          edge_r_on,
  output logic          L,
  output logic          R,
  output logic          resetround,
  output logic [SW-1:0] score_l,
  output logic [SW-1:0] score_r,
  output logic          game_over,
  output logic          winner_r
);

  localparam int HW = $clog2(HOLD_CYCLES + 1);

  tow_state_t    state_q, state_d;
  logic [HW-1:0] hold_q, hold_d;
  logic          pulse_l, pulse_r;
  logic          right_raw;
  logic          inc_l, inc_r;
  logic          fwd_l, fwd_r;

`ifdef CPU_PLAYER_EN
  logic [LFSR_W-1:0] lfsr_q;

  // Fibonacci LFSR, taps 10 and 7
  always_ff @(posedge clk) begin
    if (reset) lfsr_q <= LFSR_SEED;
    else       lfsr_q <= {lfsr_q[LFSR_W-2:0], lfsr_q[9] ^ lfsr_q[6]};
  end

  assign right_raw = (lfsr_q < LFSR_W'(CPU_THRESH));
`else
  assign right_raw = key_r;
`endif

  key_pulse u_key_l (
    .clk   (clk),
    .reset (reset),
    .raw   (key_l),
    .pulse (pulse_l)
  );

  key_pulse u_key_r (
    .clk   (clk),
    .reset (reset),
    .raw   (right_raw),
    .pulse (pulse_r)
  );

  // NOTE: every signal this block drives gets a default first; a path that skips an
  // assignment would otherwise infer a latch.
  always_comb begin
    state_d    = state_q;
    hold_d     = hold_q;
    L          = 1'b0;
    R          = 1'b0;
    resetround = 1'b0;
    inc_l      = 1'b0;
    inc_r      = 1'b0;
    fwd_l      = pulse_l & ~pulse_r;
    fwd_r      = pulse_r & ~pulse_l;

    unique case (state_q)
      PLAY: begin
        L = fwd_l;
        R = fwd_r;
        if (fwd_l && edge_l_on) begin
          inc_l = 1'b1;
          if (score_l == SW'(SCORE_MAX - 1)) begin
            state_d = OVER;
          end else begin
            state_d = POINT;
            hold_d  = '0;
          end
        end else if (fwd_r && edge_r_on) begin
          inc_r = 1'b1;
          if (score_r == SW'(SCORE_MAX - 1)) begin
            state_d = OVER;
          end else begin
            state_d = POINT;
            hold_d  = '0;
          end
        end
      end
      POINT: begin
        if (hold_q == HW'(HOLD_CYCLES - 1)) state_d = RECENTER;
        else                                hold_d  = hold_q + 1'b1;
      end
      RECENTER: begin
        resetround = 1'b1;
        state_d    = PLAY;
      end
      OVER: begin
        resetround = 1'b1;
      end
      default: state_d = PLAY;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= PLAY;
      hold_q   <= '0;
      score_l  <= '0;
      score_r  <= '0;
      winner_r <= 1'b0;
    end else begin
      state_q <= state_d;
      hold_q  <= hold_d;
      if (inc_l) score_l <= score_l + 1'b1;
      if (inc_r) score_r <= score_r + 1'b1;
      if (inc_r && state_d == OVER) winner_r <= 1'b1;
    end
  end

  assign game_over = (state_q == OVER);

endmodule : tug_of_war_ctrl
